ibex_bus_responder: RTL
=======================

// Module: ibex_bus_responder
// PURPOSE
// - Memory-side responder for the Ibex req/gnt/rvalid bus, usable as either the instruction or the data port.
// - Answers core-issued requests from an internal word array, in order, with fixed configurable latency.
// - Flags out-of-range accesses as bus errors.
// - Used in simulation tops and FPGA bring-up as the slave counterpart of the core's fetch and LSU initiators.
// PARAMETERS
// - MemWords        1024      depth of the 32-bit word array; power of two, >= 2
// - AddrBase        32'h0     byte address of word 0; aligned to 4*MemWords
// - RespLatency     1         cycles from grant to rvalid; legal range 1..4
// - MaxOutstanding  2         response-queue depth (granted, not yet answered); legal range 1..4
// PORTS
// - clk_i      in   1   clock; all state updates on the rising edge
// - rst_i      in   1   synchronous reset, active-high
// - req_i      in   1   initiator request valid
// - gnt_o      out  1   request accepted this cycle
// - we_i       in   1   1 = write, 0 = read; tied 0 for instruction fetch
// - be_i       in   4   byte enables for writes
// - addr_i     in   32  byte address; addr_i[1:0] ignored
// - wdata_i    in   32  write data
// - rvalid_o   out  1   response valid; one pulse per granted request
// - rdata_o    out  32  read data; 0 on write responses and on error responses
// - err_o      out  1   error flag, qualified by rvalid_o
// - stall_i    in   1   grant back-pressure; present only with IBEX_BUS_RESP_STALL_EN
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
// - Reset values: gnt_o=0 (combinational, also gated by rst_i), rvalid_o=0, rdata_o=0, err_o=0; queue empty.
// - Memory contents are not reset.
// - Grant rule: gnt_o = req_i & ~rst_i & (count < MaxOutstanding).
//   - No same-cycle pop bypass: when full, gnt stays 0 even if rvalid fires this cycle.
// - Address decode: in range when AddrBase <= addr_i < AddrBase + 4*MemWords.
//   - Word index = (addr_i - AddrBase) >> 2.
// - Access at grant:
//   - Writes update the bytes selected by be_i in the grant cycle. be_i=0 is legal and writes nothing.
//   - Reads sample the array in the grant cycle, after any earlier write has committed.
//   - A read granted the cycle after a write to the same word returns the new data.
// - Out-of-range access: no array access, no write; response carries err=1, rdata=0.
// - Queue: each grant pushes {rdata, err, cnt=RespLatency-1}.
//   - Every cycle, cnt of all valid entries decrements, saturating at 0.
//   - The head pops when its cnt==0.
// - Response timing:
//   - Pop drives registered rvalid_o=1 with that entry's rdata/err the next cycle.
//   - Latency is exactly RespLatency cycles after the grant edge, with no idle back-to-back gaps.
//   - Responses are strictly in grant order. The head pops at most once per cycle.
//   - rvalid_o holds for exactly one cycle per response.
// - Simultaneous push and pop: count unchanged; both take effect.
// - Queue full: gnt_o=0 while req_i=1; the initiator holds req and address stable; no requests are dropped.
// - Reset mid-operation:
//   - Queued and in-flight responses are discarded.
//   - No rvalid in the cycle after rst_i is sampled high.
//   - Writes already granted stay committed.
// - Protocol violation (req_i dropped before gnt) is legal; nothing is queued.
// CONFIGURATION
// - IBEX_BUS_RESP_STALL_EN defined:
//   - stall_i port exists; gnt_o is additionally ANDed with ~stall_i.
//   - Queued responses keep draining during stall.
// - IBEX_BUS_RESP_STALL_EN undefined:
//   - stall_i port is absent; grant depends only on req and queue occupancy.
// TESTING
// - Reset: rst_i=1 for 2 cycles with req_i=1 -> gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0 throughout.
// - Write then read, RespLatency=1:
//   - Stimulus: write 0xDEADBEEF to 0x10 (be=4'hF), then read 0x10 the next cycle.
//   - Response: both granted immediately; rvalid 1 cycle after each grant; read returns 0xDEADBEEF, err=0.
// - Byte enables: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> read 0x20 returns 0x11BB33DD.
// - Out of range, MemWords=1024, AddrBase=0:
//   - Stimulus: write 0x1000, then read 0x1000.
//   - Response: err=1 and rdata=0 on both; a later read of 0x0 is unchanged.
// - Full queue, MaxOutstanding=2, RespLatency=3:
//   - Stimulus: req_i held for 4 back-to-back reads.
//   - Response: gnt pattern 1,1,0,0,0,1,1; 4 rvalids, in order, each exactly 3 cycles after its grant.
// - Reset mid-flight: 2 reads granted, rst_i pulsed 1 cycle later -> no rvalid after reset; count=0; the next req is granted at once.

Source files
------------

// File: rtl/ibex_bus_responder.sv
// ibex_bus_responder: memory-side responder for the Ibex req/gnt/rvalid bus.
// Serves in-order responses from a 32-bit word array with fixed latency and
// flags out-of-range accesses as bus errors.
// Optional feature: define IBEX_BUS_RESP_STALL_EN to add the stall_i grant
// back-pressure input.
module ibex_bus_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
`ifdef IBEX_BUS_RESP_STALL_EN
  ,
  input  logic        stall_i
`endif
);

  localparam int unsigned IdxW     = $clog2(MemWords);
  localparam logic [31:0] MemBytes = 32'(4 * MemWords);
  localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);
  localparam logic [1:0]  LatInit  = 2'(RespLatency - 1);
  localparam logic [1:0]  LastPtr  = 2'(MaxOutstanding - 1);

  logic [31:0]     mem_q [MemWords];

  logic [32:0]     diff;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word;
  logic            stall;

  // Queue storage is sized for the largest legal MaxOutstanding.
  logic [31:0] q_data_q [4];
  logic [31:0] q_data_d [4];
  logic        q_err_q  [4];
  logic        q_err_d  [4];
  logic [1:0]  q_cnt_q  [4];
  logic [1:0]  q_cnt_d  [4];
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  stored_q, stored_d;
  logic [2:0]  count_q, count_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef IBEX_BUS_RESP_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Borrow bit of the subtraction gives the lower bound without a constant compare.
  assign diff     = {1'b0, addr_i} - {1'b0, AddrBase};
  assign offset   = diff[31:0];
  assign in_range = ~diff[32] & (offset < MemBytes);
  assign idx      = offset[IdxW+1:2];
  assign rd_word  = (in_range && !we_i) ? mem_q[idx] : '0;

  // count_q covers queued entries plus the response currently on rvalid_o,
  // so a slot frees only once its response has been presented.
  assign gnt_o    = req_i & ~rst_i & ~stall & (count_q < MaxOut);
  assign pop      = (stored_q != 3'd0) && (q_cnt_q[head_q] == 2'd0);

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Byte-enabled array write in the grant cycle; the array is never reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Next-state for the response queue: age all entries, pop head, push grant.
  always_comb begin
    q_data_d = q_data_q;
    q_err_d  = q_err_q;
    for (int unsigned i = 0; i < 4; i++) begin
      q_cnt_d[i] = (q_cnt_q[i] != 2'd0) ? q_cnt_q[i] - 2'd1 : 2'd0;
    end
    head_d   = head_q;
    tail_d   = tail_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (pop) begin
      rvalid_d = 1'b1;
      rdata_d  = q_data_q[head_q];
      err_d    = q_err_q[head_q];
      head_d   = ptr_inc(head_q);
    end
    if (gnt_o) begin
      q_data_d[tail_q] = rd_word;
      q_err_d[tail_q]  = ~in_range;
      q_cnt_d[tail_q]  = LatInit;
      tail_d           = ptr_inc(tail_q);
    end
    stored_d = stored_q + 3'(gnt_o) - 3'(pop);
    count_d  = count_q + 3'(gnt_o) - 3'(rvalid_q);
  end

  // Queue payload registers; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    q_data_q <= q_data_d;
    q_err_q  <= q_err_d;
    q_cnt_q  <= q_cnt_d;
  end

  // Queue control and registered response outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      stored_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      stored_q <= stored_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
